bitfield_pipe: RTL

// - Parametrised, pipelined successor to the 32-bit combinational low-bit cut: generalises
//   "keep low n bits" into a bit-field unit (CUT, zero/sign EXTRACT, INSERT) of any WIDTH.
// - Sits in the ALU datapath beside the shifters; 2-stage pipeline with valid/ready on both

---
 rtl/bitfield_pipe.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/bitfield_pipe.sv
// bitfield_pipe: pipelined bit-field unit (CUT, zero/sign EXTRACT, INSERT) for the ALU datapath.
//
// Stage 1 registers the request together with the clamped field length, the field mask and the
// error flag. Stage 2 applies the selected operation and holds the result until it is consumed.
// Both sides use valid/ready handshakes, so the unit can stall behind a busy writeback.
//
// Ports:
//   clk       in   1      clock, all state updates on the rising edge
//   rst       in   1      synchronous active-high reset, drops every in-flight request
//   in_valid  in   1      request present
//   in_ready  out  1      request accepted when in_valid && in_ready
//   mode      in   2      00 CUT, 01 EXTRACT_Z, 10 EXTRACT_S, 11 INSERT
//   pos       in   CW     field LSB position (ignored by CUT)
//   len       in   CW     field length in bits
//   in_data   in   WIDTH  source operand
//   ins_data  in   WIDTH  insert operand, low len bits used (INSERT only)
//   out_valid out  1      result present
//   out_ready in   1      result consumed when out_valid && out_ready
//   out_data  out  WIDTH  result
//   out_err   out  1      field clipped or out of range, qualifies out_data

module bitfield_pipe #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       mode,
  input  logic [CW-1:0]    pos,
  input  logic [CW-1:0]    len,
  input  logic [WIDTH-1:0] in_data,
  input  logic [WIDTH-1:0] ins_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_err
);

  typedef enum logic [1:0] {
    ModeCut  = 2'b00,
    ModeExtZ = 2'b01,
    ModeExtS = 2'b10,
    ModeIns  = 2'b11
  } mode_e;

  // Length/position arithmetic is done one bit wider than the ports so pos + len cannot wrap.
  localparam logic [CW:0]    WidthX = WIDTH[CW:0];
  localparam logic [WIDTH:0] OneX   = {{WIDTH{1'b0}}, 1'b1};

  // ---------------------------------------------------------------------------------------------
  // Handshake control
  // ---------------------------------------------------------------------------------------------
  logic s1_valid_q, s2_valid_q;
  logic s2_load, accept;

  // s2 takes a new entry when it is empty or its current result leaves this cycle.
  assign s2_load  = !s2_valid_q || out_ready;
  // s1 advances exactly when s2 loads, so it can accept when empty or advancing.
  assign in_ready = !s1_valid_q || s2_load;
  assign accept   = in_valid && in_ready;

  // ---------------------------------------------------------------------------------------------
  // Stage 1 combinational: clamp the length, clip the field at the MSB, build the mask
  // ---------------------------------------------------------------------------------------------
  mode_e          mode_in;
  logic [CW:0]    len_x, pos_x, sum_x, room_x, eff_len, fld_len;
  logic           pos_oob, len_over, err_in;
  logic [WIDTH:0] one_sh, mask_x;
  logic [WIDTH-1:0] mask_in;

  always_comb begin
    mode_in  = mode_e'(mode);
    len_x    = {1'b0, len};
    pos_x    = {1'b0, pos};
    sum_x    = pos_x + len_x;
    len_over = len_x > WidthX;
    eff_len  = len_over ? WidthX : len_x;
    pos_oob  = pos_x >= WidthX;
    room_x   = pos_oob ? '0 : (WidthX - pos_x);

    // CUT ignores pos; every other mode only keeps the part of the field that fits below the MSB.
    if (mode_in == ModeCut) begin
      fld_len = eff_len;
    end else begin
      fld_len = (eff_len < room_x) ? eff_len : room_x;
    end

    err_in = len_over || ((mode_in != ModeCut) && (pos_oob || (sum_x > WidthX)));

    // (1 << n) - 1 in WIDTH+1 bits gives all ones for n == WIDTH and zero for n == 0.
    one_sh  = OneX << fld_len;
    mask_x  = one_sh - OneX;
    mask_in = mask_x[WIDTH-1:0];
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------------------------------
  mode_e            s1_mode_q;
  logic [CW-1:0]    s1_pos_q;
  logic [WIDTH-1:0] s1_mask_q;
  logic             s1_pos_oob_q;
  logic             s1_err_q;
  logic [WIDTH-1:0] s1_in_q;
  logic [WIDTH-1:0] s1_ins_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
    end else if (in_ready) begin
      s1_valid_q <= in_valid;
    end
  end

  // Payload registers need no reset: they only reach stage 2 behind a set valid bit.
  always_ff @(posedge clk) begin
    if (accept) begin
      s1_mode_q    <= mode_in;
      s1_pos_q     <= pos;
      s1_mask_q    <= mask_in;
      s1_pos_oob_q <= pos_oob;
      s1_err_q     <= err_in;
      s1_in_q      <= in_data;
      s1_ins_q     <= ins_data;
    end
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2 combinational: apply the operation
  // ---------------------------------------------------------------------------------------------
  logic [WIDTH-1:0] ext_z, ext_s, ins_res, top_bit, res;
  logic             sign;

  always_comb begin
    ext_z   = (s1_in_q >> s1_pos_q) & s1_mask_q;
    // Highest set bit of the mask marks the field's sign position; a zero mask yields no sign.
    top_bit = s1_mask_q & ~(s1_mask_q >> 1);
    sign    = |(ext_z & top_bit);
    ext_s   = sign ? (ext_z | ~s1_mask_q) : ext_z;

    if (s1_pos_oob_q) begin
      ins_res = s1_in_q;
    end else begin
      ins_res = (s1_in_q & ~(s1_mask_q << s1_pos_q)) | ((s1_ins_q & s1_mask_q) << s1_pos_q);
    end

    res = '0;
    unique case (s1_mode_q)
      ModeCut:  res = s1_in_q & s1_mask_q;
      ModeExtZ: res = ext_z;
      ModeExtS: res = ext_s;
      ModeIns:  res = ins_res;
      default:  res = '0;
    endcase
  end

  // ---------------------------------------------------------------------------------------------
  // Stage 2 registers (drive the outputs directly)
  // ---------------------------------------------------------------------------------------------
  logic [WIDTH-1:0] s2_data_q;
  logic             s2_err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      s2_err_q   <= 1'b0;
    end else if (s2_load) begin
      s2_valid_q <= s1_valid_q;
      // Keep the last result when nothing new arrives so out_data never picks up stale s1 payload.
      if (s1_valid_q) begin
        s2_data_q <= res;
        s2_err_q  <= s1_err_q;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign out_data  = s2_data_q;
  assign out_err   = s2_err_q;

endmodule
